// File: rtl/pc_pkg.sv
// Shared definitions for the PC generator: FSM state encoding and default
// width, reset PC and sequential increment.
package pc_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_e;

   localparam int          DEF_XLEN     = 32;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam int          DEF_PC_INC   = 4;

endpackage

// File: rtl/pc_redir_arb.sv
// Fixed-priority redirect arbiter: one-hot grant of the lowest-index request,
// plus a flag saying whether any request was granted.
module pc_redir_arb #(
   parameter int NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0] valid,
   output logic [NUM_SRC-1:0] grant,
   output logic               any
);

   always_comb begin
      grant = '0;
      any   = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (valid[i] && !any) begin
            grant[i] = 1'b1;
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator with BOOT/RUN/HALT control and prioritised redirects.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_CHECK_EN.
module pc_gen
   import pc_pkg::*;
#(
   parameter int              XLEN     = DEF_XLEN,
   parameter int              NUM_SRC  = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
   parameter int              PC_INC   = DEF_PC_INC
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_SRC-1:0]      redir_valid,
   input  logic [NUM_SRC*XLEN-1:0] redir_target,
   input  logic                    stall,
   input  logic                    halt_req,
   input  logic                    fetch_ready,
   output logic                    fetch_valid,
   output logic [XLEN-1:0]         fetch_pc,
   output logic [NUM_SRC-1:0]      redir_grant,
   output logic                    misalign,
   output logic [XLEN-1:0]         misalign_addr
);

   pc_state_e           state;
   pc_state_e           state_next;
   logic [NUM_SRC-1:0]  arb_grant;
   logic                arb_any;
   logic                redir_any;
   logic [XLEN-1:0]     redir_pc;
   logic [XLEN-1:0]     pc_next;

   pc_redir_arb #(
      .NUM_SRC (NUM_SRC)
   ) u_arb (
      .valid (redir_valid),
      .grant (arb_grant),
      .any   (arb_any)
   );

   // Reset wins over any concurrent redirect, so nothing is reported as granted.
   assign redir_grant = rst ? '0 : arb_grant;
   assign redir_any   = arb_any & ~rst;

   always_comb begin
      redir_pc = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (arb_grant[i]) begin
            redir_pc = redir_pc | redir_target[i*XLEN +: XLEN];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   // Redirects never alter the control state; only halt_req does.
   always_comb begin
      state_next = state;
      case (state)
         BOOT:    state_next = halt_req ? HALT : RUN;
         RUN:     if (halt_req) state_next = HALT;
         HALT:    if (!halt_req) state_next = RUN;
         default: state_next = BOOT;
      endcase
   end

   assign fetch_valid = (state == RUN);

`ifdef PC_MISALIGN_CHECK_EN
   logic            bad_target;
   logic            mis_next;
   logic [XLEN-1:0] maddr_next;

   assign bad_target = redir_any && (redir_pc[1:0] != 2'b00);

   always_comb begin
      mis_next   = bad_target;
      maddr_next = bad_target ? redir_pc : misalign_addr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         misalign      <= 1'b0;
         misalign_addr <= '0;
      end else begin
         misalign      <= mis_next;
         misalign_addr <= maddr_next;
      end
   end
`else
   logic bad_target;

   assign bad_target    = 1'b0;
   assign misalign      = 1'b0;
   assign misalign_addr = '0;
`endif

   // A trapped misaligned target freezes the PC rather than falling through to increment.
   always_comb begin
      pc_next = fetch_pc;
      if (redir_any) begin
         if (!bad_target) begin
            pc_next = redir_pc;
         end
      end else if (state == RUN && fetch_ready && !stall) begin
         pc_next = fetch_pc + XLEN'(PC_INC);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
      end else begin
         fetch_pc <= pc_next;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: each step drives inputs, queues the expected
// post-edge outputs, then pops and compares them after the clock edge.
module tb_pc_gen;

   logic          clk;
   logic          rst;
   logic [3:0]    redir_valid;
   logic [127:0]  redir_target;
   logic          stall;
   logic          halt_req;
   logic          fetch_ready;
   logic          fetch_valid;
   logic [31:0]   fetch_pc;
   logic [3:0]    redir_grant;
   logic          misalign;
   logic [31:0]   misalign_addr;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        mis;
      logic [31:0] maddr;
   } exp_t;

   exp_t  expQ[$];
   string tagQ[$];
   int    checks;
   int    errors;
   logic [31:0] stickyAddr;

   pc_gen #(
      .XLEN     (32),
      .NUM_SRC  (4),
      .RESET_PC (32'h0000_0000),
      .PC_INC   (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .redir_valid   (redir_valid),
      .redir_target  (redir_target),
      .stall         (stall),
      .halt_req      (halt_req),
      .fetch_ready   (fetch_ready),
      .fetch_valid   (fetch_valid),
      .fetch_pc      (fetch_pc),
      .redir_grant   (redir_grant),
      .misalign      (misalign),
      .misalign_addr (misalign_addr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [127:0] tg(input int idx, input logic [31:0] val);
      logic [127:0] v;
      v = '0;
      v[idx*32 +: 32] = val;
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(
      input string        tag,
      input logic         r,
      input logic [3:0]   v,
      input logic [127:0] t,
      input logic         s,
      input logic         h,
      input logic         rdy,
      input logic [3:0]   expGrant,
      input logic         expValid,
      input logic [31:0]  expPc,
      input logic         expMis,
      input logic [31:0]  expMaddr
   );
      exp_t  e;
      exp_t  got;
      string gotTag;
      rst          = r;
      redir_valid  = v;
      redir_target = t;
      stall        = s;
      halt_req     = h;
      fetch_ready  = rdy;
      #1;
      if (!r) checkOutput({tag, "_grant"}, 64'(redir_grant), 64'(expGrant));
      e.valid = expValid;
      e.pc    = expPc;
      e.mis   = expMis;
      e.maddr = expMaddr;
      expQ.push_back(e);
      tagQ.push_back(tag);
      @(posedge clk);
      #1;
      if (expQ.size() == 0) begin
         checkOutput({tag, "_queue"}, 64'd0, 64'd1);
      end else begin
         got    = expQ.pop_front();
         gotTag = tagQ.pop_front();
         checkOutput({gotTag, "_valid"}, 64'(fetch_valid), 64'(got.valid));
         checkOutput({gotTag, "_pc"}, 64'(fetch_pc), 64'(got.pc));
         checkOutput({gotTag, "_mis"}, 64'(misalign), 64'(got.mis));
         checkOutput({gotTag, "_maddr"}, 64'(misalign_addr), 64'(got.maddr));
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      stickyAddr = 32'h0;

      applyStimulus("rst0", 1, 4'b0000, '0, 0, 0, 1, 4'b0000, 0, 32'h0, 0, 32'h0);
      applyStimulus("rst1", 1, 4'b0000, '0, 0, 0, 1, 4'b0000, 0, 32'h0, 0, 32'h0);
      applyStimulus("boot", 0, 4'b0000, '0, 0, 0, 1, 4'b0000, 1, 32'h0, 0, 32'h0);
      applyStimulus("seq4", 0, 4'b0000, '0, 0, 0, 1, 4'b0000, 1, 32'h4, 0, 32'h0);
      applyStimulus("seq8", 0, 4'b0000, '0, 0, 0, 1, 4'b0000, 1, 32'h8, 0, 32'h0);
      applyStimulus("nordy0", 0, 4'b0000, '0, 0, 0, 0, 4'b0000, 1, 32'h8, 0, 32'h0);
      applyStimulus("nordy1", 0, 4'b0000, '0, 0, 0, 0, 4'b0000, 1, 32'h8, 0, 32'h0);

      applyStimulus("prio", 0, 4'b0110, tg(1, 32'h100) | tg(2, 32'h200), 0, 0, 1,
                    4'b0010, 1, 32'h100, 0, 32'h0);
      applyStimulus("post_prio", 0, 4'b0000, '0, 0, 0, 1, 4'b0000, 1, 32'h104, 0, 32'h0);

      applyStimulus("stall_redir", 0, 4'b1000, tg(3, 32'h80), 1, 0, 1, 4'b1000, 1, 32'h80, 0, 32'h0);
      applyStimulus("stall_hold0", 0, 4'b0000, '0, 1, 0, 1, 4'b0000, 1, 32'h80, 0, 32'h0);
      applyStimulus("stall_hold1", 0, 4'b0000, '0, 1, 0, 1, 4'b0000, 1, 32'h80, 0, 32'h0);
      applyStimulus("unstall", 0, 4'b0000, '0, 0, 0, 1, 4'b0000, 1, 32'h84, 0, 32'h0);

      applyStimulus("to40", 0, 4'b0001, tg(0, 32'h40), 0, 0, 1, 4'b0001, 1, 32'h40, 0, 32'h0);
      applyStimulus("halt_enter", 0, 4'b0000, '0, 0, 1, 0, 4'b0000, 0, 32'h40, 0, 32'h0);
      applyStimulus("halt_redir", 0, 4'b0001, tg(0, 32'h300), 0, 1, 1, 4'b0001, 0, 32'h300, 0, 32'h0);
      applyStimulus("halt_hold", 0, 4'b0000, '0, 0, 1, 1, 4'b0000, 0, 32'h300, 0, 32'h0);
      applyStimulus("halt_exit", 0, 4'b0000, '0, 0, 0, 1, 4'b0000, 1, 32'h300, 0, 32'h0);
      applyStimulus("run_304", 0, 4'b0000, '0, 0, 0, 1, 4'b0000, 1, 32'h304, 0, 32'h0);

      applyStimulus("all_src", 0, 4'b1111,
                    tg(0, 32'hFFFF_FFFC) | tg(1, 32'h10) | tg(2, 32'h20) | tg(3, 32'h30),
                    0, 0, 1, 4'b0001, 1, 32'hFFFF_FFFC, 0, 32'h0);
      applyStimulus("wrap", 0, 4'b0000, '0, 0, 0, 1, 4'b0000, 1, 32'h0, 0, 32'h0);

`ifdef PC_MISALIGN_CHECK_EN
      applyStimulus("misalign", 0, 4'b0100, tg(2, 32'h102), 0, 0, 0, 4'b0100, 1, 32'h0, 1, 32'h102);
      stickyAddr = 32'h102;
      applyStimulus("mis_after", 0, 4'b0000, '0, 0, 0, 0, 4'b0000, 1, 32'h0, 0, stickyAddr);
      applyStimulus("mis_seq", 0, 4'b0000, '0, 0, 0, 1, 4'b0000, 1, 32'h4, 0, stickyAddr);
`else
      applyStimulus("odd_load", 0, 4'b0100, tg(2, 32'h102), 0, 0, 0, 4'b0100, 1, 32'h102, 0, 32'h0);
      applyStimulus("odd_after", 0, 4'b0000, '0, 0, 0, 0, 4'b0000, 1, 32'h102, 0, 32'h0);
      applyStimulus("odd_seq", 0, 4'b0000, '0, 0, 0, 1, 4'b0000, 1, 32'h106, 0, 32'h0);
`endif

      applyStimulus("rst_redir", 1, 4'b0001, tg(0, 32'h500), 0, 0, 1, 4'b0000, 0, 32'h0, 0, 32'h0);
      applyStimulus("boot_halt", 0, 4'b0000, '0, 0, 1, 1, 4'b0000, 0, 32'h0, 0, 32'h0);
      applyStimulus("halt_exit2", 0, 4'b0000, '0, 0, 0, 1, 4'b0000, 1, 32'h0, 0, 32'h0);
      applyStimulus("seq_after", 0, 4'b0000, '0, 0, 0, 1, 4'b0000, 1, 32'h4, 0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
